// File: rtl/acq_detect.sv
// acq_detect: non-coherent |I|+|Q| acquisition detector with a
// search/confirm FSM that drives half-chip code-phase slips.
module acq_detect #(
   parameter int DW        = 20,
   parameter int EW        = 24,
   parameter int NONCOH    = 4,
   parameter int CONF_HITS = 3,
   parameter int CONF_TRY  = 4,
   parameter int SLIP_MAX  = 2046
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic          epoch,
   input  logic [DW-1:0] i_acc,
   input  logic [DW-1:0] q_acc,
   input  logic [EW-1:0] threshold,
   output logic          slip_req,
   output logic          busy,
   output logic          locked,
   output logic          fail,
   output logic [10:0]   slip_cnt,
   output logic [EW-1:0] dwell_energy,
   output logic [EW-1:0] peak_energy
);
   localparam int CW = (NONCOH > 1) ? $clog2(NONCOH) : 1;
   localparam int HW = $clog2(CONF_TRY + 1);

   typedef enum logic [2:0] {
      IDLE, SEARCH, CONFIRM, SLIP, LOCKED, FAILED
   } state_t;

   state_t        state, nxt;
   logic          pend;
   logic [CW-1:0] ecnt;
   logic [EW-1:0] sum, energy;
   logic [HW-1:0] hits, tries, hits_n, tries_n;
   logic [DW:0]   mag;
   logic [EW:0]   tot;
   logic          last, hit, abort, take;

   // the most negative input has no positive twin: clamp it
   function automatic logic [DW-1:0] absval(input logic [DW-1:0] x);
      if (!x[DW-1]) return x;
      if (x[DW-2:0] == '0) return {1'b0, {(DW-1){1'b1}}};
      return -x;
   endfunction

   always_comb begin
      mag     = {1'b0, absval(i_acc)} + {1'b0, absval(q_acc)};
      tot     = {1'b0, sum} + {1'b0, EW'(mag)};
      energy  = tot[EW] ? '1 : tot[EW-1:0];
      hit     = energy >= threshold;
      last    = ecnt == CW'(NONCOH - 1);
      hits_n  = hits + HW'(hit);
      tries_n = tries + HW'(1);
      abort   = (CONF_TRY - int'(tries_n)) < (CONF_HITS - int'(hits_n));
      take    = epoch && ((state == SEARCH && !pend) || state == CONFIRM);
   end

   always_comb begin
      nxt = state;
      if (start) begin
         nxt = SEARCH;
      end else begin
         unique case (state)
            SEARCH: begin
               if (take && last) nxt = hit ? CONFIRM : SLIP;
            end
            CONFIRM: begin
               if (take && last) begin
                  if (hits_n == HW'(CONF_HITS)) nxt = LOCKED;
                  else if (abort)               nxt = SLIP;
               end
            end
            SLIP: begin
               nxt = (slip_cnt == 11'(SLIP_MAX)) ? FAILED : SEARCH;
            end
            default: nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state        <= IDLE;
         pend         <= 1'b0;
         ecnt         <= '0;
         sum          <= '0;
         hits         <= '0;
         tries        <= '0;
         slip_req     <= 1'b0;
         busy         <= 1'b0;
         locked       <= 1'b0;
         fail         <= 1'b0;
         slip_cnt     <= '0;
         dwell_energy <= '0;
         peak_energy  <= '0;
      end else begin
         state    <= nxt;
         busy     <= nxt inside {SEARCH, CONFIRM, SLIP};
         locked   <= nxt == LOCKED;
         fail     <= nxt == FAILED;
         slip_req <= 1'b0;
         if (start) begin
            pend        <= 1'b1;
            ecnt        <= '0;
            sum         <= '0;
            hits        <= '0;
            tries       <= '0;
            slip_cnt    <= '0;
            peak_energy <= '0;
         end else if (state == SLIP) begin
            // an epoch here straddles the slip, so it is the discard
            if (epoch) pend <= 1'b0;
         end else if (state == SEARCH && epoch && pend) begin
            pend <= 1'b0;
         end else if (take) begin
            if (last) begin
               ecnt         <= '0;
               sum          <= '0;
               dwell_energy <= energy;
               if (energy > peak_energy) peak_energy <= energy;
               if (state == SEARCH) begin
                  hits  <= '0;
                  tries <= '0;
               end else begin
                  hits  <= hits_n;
                  tries <= tries_n;
               end
               if (nxt == SLIP) begin
                  slip_req <= 1'b1;
                  slip_cnt <= slip_cnt + 11'd1;
                  pend     <= 1'b1;
               end
            end else begin
               ecnt <= ecnt + CW'(1);
               sum  <= energy;
            end
         end
      end
   end

endmodule

// File: tb/tb_acq_detect.sv
// tb_acq_detect: directed and randomized checks of four acq_detect
// instances against a dwell-level behavioural model.
module tb_acq_detect;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr = 1'b0, start = 1'b0, epoch = 1'b0;
   logic [19:0] i_acc = '0, q_acc = '0;
   logic [23:0] thr = '0;
   logic [3:0]  sr, by, lk, fl;
   logic [10:0] sc [4];
   logic [23:0] dw [4], pk [4];
   logic [20:0] dw3, pk3;
   assign dw[3] = {3'b0, dw3};
   assign pk[3] = {3'b0, pk3};

   acq_detect d0 (
      .clk(clk), .clr(clr), .start(start), .epoch(epoch),
      .i_acc(i_acc), .q_acc(q_acc), .threshold(thr),
      .slip_req(sr[0]), .busy(by[0]), .locked(lk[0]), .fail(fl[0]),
      .slip_cnt(sc[0]), .dwell_energy(dw[0]), .peak_energy(pk[0]));

   acq_detect #(.NONCOH(1)) d1 (
      .clk(clk), .clr(clr), .start(start), .epoch(epoch),
      .i_acc(i_acc), .q_acc(q_acc), .threshold(thr),
      .slip_req(sr[1]), .busy(by[1]), .locked(lk[1]), .fail(fl[1]),
      .slip_cnt(sc[1]), .dwell_energy(dw[1]), .peak_energy(pk[1]));

   acq_detect #(.NONCOH(1), .SLIP_MAX(4)) d2 (
      .clk(clk), .clr(clr), .start(start), .epoch(epoch),
      .i_acc(i_acc), .q_acc(q_acc), .threshold(thr),
      .slip_req(sr[2]), .busy(by[2]), .locked(lk[2]), .fail(fl[2]),
      .slip_cnt(sc[2]), .dwell_energy(dw[2]), .peak_energy(pk[2]));

   acq_detect #(.EW(21)) d3 (
      .clk(clk), .clr(clr), .start(start), .epoch(epoch),
      .i_acc(i_acc), .q_acc(q_acc), .threshold(thr[20:0]),
      .slip_req(sr[3]), .busy(by[3]), .locked(lk[3]), .fail(fl[3]),
      .slip_cnt(sc[3]), .dwell_energy(dw3), .peak_energy(pk3));

   // model: 0 idle, 1 searching, 2 confirming, 3 locked, 4 failed
   int          mode [4];
   bit          disc [4];
   int unsigned mq [4][$];
   bit          mres [4][$];
   int          slips [4];
   int unsigned mdw [4], mpk [4];
   bit          pulse [4], seen [4];
   int          nslip [4] = '{default: 0};
   int          base [4];
   int          checks = 0, failures = 0;

   always @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (sr[k] === 1'b1) nslip[k] <= nslip[k] + 1;

   function automatic int nco(int k);
      return (k == 1 || k == 2) ? 1 : 4;
   endfunction

   function automatic int unsigned emax(int k);
      return (k == 3) ? 32'd2097151 : 32'd16777215;
   endfunction

   function automatic int smax(int k);
      return (k == 2) ? 4 : 2046;
   endfunction

   function automatic int unsigned absm(int v);
      if (v == -524288) return 524287;
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_slip(int k);
      slips[k]++;
      pulse[k] = 1'b1;
      disc[k]  = 1'b1;
      mode[k]  = (slips[k] == smax(k)) ? 4 : 1;
   endtask

   task automatic model_epoch(int iv, int qv);
      for (int k = 0; k < 4; k++) begin
         int unsigned e;
         int h;
         bit hit;
         pulse[k] = 1'b0;
         if (mode[k] == 1 && disc[k]) begin
            disc[k] = 1'b0;
            continue;
         end
         if (mode[k] != 1 && mode[k] != 2) continue;
         mq[k].push_back(absm(iv) + absm(qv));
         if (mq[k].size() < nco(k)) continue;
         e = 0;
         foreach (mq[k][j]) e += mq[k][j];
         if (e > emax(k)) e = emax(k);
         mq[k].delete();
         mdw[k] = e;
         if (e > mpk[k]) mpk[k] = e;
         hit = e >= (thr & emax(k));
         if (mode[k] == 1) begin
            if (hit) begin
               mode[k] = 2;
               mres[k].delete();
            end else model_slip(k);
         end else begin
            mres[k].push_back(hit);
            h = 0;
            foreach (mres[k][j]) h += int'(mres[k][j]);
            if (h == 3) mode[k] = 3;
            else if (4 - int'(mres[k].size()) < 3 - h) model_slip(k);
         end
      end
   endtask

   task automatic drive_epoch(int iv, int qv);
      @(posedge clk);
      #1;
      epoch = 1'b1;
      i_acc = iv[19:0];
      q_acc = qv[19:0];
      model_epoch(iv, qv);
      @(posedge clk);
      #1;
      epoch = 1'b0;
      for (int k = 0; k < 4; k++) seen[k] = sr[k];
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_start(bit with_ep);
      @(posedge clk);
      #1;
      start = 1'b1;
      epoch = with_ep;
      i_acc = 20'($urandom);
      q_acc = 20'($urandom);
      @(posedge clk);
      #1;
      start = 1'b0;
      epoch = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mode[k]  = 1;
         disc[k]  = 1'b1;
         mq[k].delete();
         mres[k].delete();
         slips[k] = 0;
         mpk[k]   = 0;
         pulse[k] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) base[k] = nslip[k];
   endtask

   task automatic test_reset;
      clr   = 1'b0;
      start = 1'($urandom);
      epoch = 1'($urandom);
      i_acc = 20'($urandom);
      q_acc = 20'($urandom);
      thr   = 24'($urandom);
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({sr[k], by[k], lk[k], fl[k]} !== 4'b0 || sc[k] !== '0 ||
             dw[k] !== '0 || pk[k] !== '0) begin
            failures++;
            $display("FAIL reset k=%0d got flags=%b sc=%0d dw=%0d pk=%0d want all 0",
                     k, {sr[k], by[k], lk[k], fl[k]}, sc[k], dw[k], pk[k]);
         end
      end
      clr   = 1'b1;
      start = 1'b0;
      epoch = 1'b0;
      thr   = '0;
      for (int k = 0; k < 4; k++) begin
         mode[k] = 0; disc[k] = 1'b0; slips[k] = 0;
         mdw[k] = 0; mpk[k] = 0; pulse[k] = 1'b0; base[k] = nslip[k];
      end
      drive_epoch(int'($urandom_range(1, 4000)), 77);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (seen[k] !== 1'b0 || by[k] !== 1'b0 || dw[k] !== '0 || sc[k] !== '0) begin
            failures++;
            $display("FAIL idle_epoch k=%0d got sr=%b busy=%b dw=%0d sc=%0d want 0",
                     k, seen[k], by[k], dw[k], sc[k]);
         end
      end
   endtask

   task automatic test_magnitude;
      thr = 24'd524290;
      do_start(1'b0);
      drive_epoch(5, 5);
      drive_epoch(-524288, -3);
      checks++;
      if (dw[1] !== 24'd524290 || seen[1] !== 1'b0 || by[1] !== 1'b1) begin
         failures++;
         $display("FAIL mag_hit got dw=%0d sr=%b busy=%b want 524290 0 1",
                  dw[1], seen[1], by[1]);
      end
      thr = 24'd524291;
      do_start(1'b0);
      drive_epoch(1, 1);
      drive_epoch(-524288, -3);
      checks++;
      if (dw[1] !== 24'd524290 || seen[1] !== 1'b1 || sc[1] !== 11'd1) begin
         failures++;
         $display("FAIL mag_miss got dw=%0d sr=%b sc=%0d want 524290 1 1",
                  dw[1], seen[1], sc[1]);
      end
   endtask

   task automatic test_search;
      thr = 24'd1000;
      do_start(1'b0);
      for (int r = 0; r < 2; r++) begin
         for (int e = 0; e < 5; e++) begin
            drive_epoch(100, 100);
            if (e == 3) begin
               checks++;
               if (seen[0] !== 1'b0 || sc[0] !== 11'(r)) begin
                  failures++;
                  $display("FAIL search_early r=%0d got sr=%b sc=%0d want 0 %0d",
                           r, seen[0], sc[0], r);
               end
            end
         end
         checks++;
         if (dw[0] !== 24'd800 || seen[0] !== 1'b1 || sc[0] !== 11'(r + 1) ||
             nslip[0] - base[0] != r + 1) begin
            failures++;
            $display("FAIL search r=%0d got dw=%0d sr=%b sc=%0d pulses=%0d want 800 1 %0d",
                     r, dw[0], seen[0], sc[0], nslip[0] - base[0], r + 1);
         end
      end
   endtask

   task automatic test_lock;
      for (int e = 0; e < 16; e++) drive_epoch(200, 200);
      checks++;
      if (lk[0] !== 1'b0 || by[0] !== 1'b1) begin
         failures++;
         $display("FAIL lock_early got locked=%b busy=%b want 0 1", lk[0], by[0]);
      end
      drive_epoch(200, 200);
      checks++;
      if (lk[0] !== 1'b1 || by[0] !== 1'b0 || sc[0] !== 11'd2 ||
          pk[0] !== 24'd1600 || nslip[0] - base[0] != 2) begin
         failures++;
         $display("FAIL lock got locked=%b busy=%b sc=%0d pk=%0d pulses=%0d want 1 0 2 1600 2",
                  lk[0], by[0], sc[0], pk[0], nslip[0] - base[0]);
      end
   endtask

   task automatic test_confirm_abort;
      thr = 24'd1000;
      do_start(1'b0);
      drive_epoch(0, 0);
      drive_epoch(600, 600);
      drive_epoch(600, 600);
      drive_epoch(1, 1);
      checks++;
      if (seen[1] !== 1'b0 || by[1] !== 1'b1) begin
         failures++;
         $display("FAIL abort_early got sr=%b busy=%b want 0 1", seen[1], by[1]);
      end
      drive_epoch(1, 1);
      checks++;
      if (seen[1] !== 1'b1 || sc[1] !== 11'd1) begin
         failures++;
         $display("FAIL abort got sr=%b sc=%0d want 1 1", seen[1], sc[1]);
      end
      drive_epoch(0, 0);
      drive_epoch(600, 600);
      drive_epoch(1, 1);
      drive_epoch(600, 600);
      drive_epoch(600, 600);
      checks++;
      if (lk[1] !== 1'b0 || seen[1] !== 1'b0) begin
         failures++;
         $display("FAIL late_lock_early got locked=%b sr=%b want 0 0", lk[1], seen[1]);
      end
      drive_epoch(600, 600);
      checks++;
      if (lk[1] !== 1'b1 || sc[1] !== 11'd1) begin
         failures++;
         $display("FAIL late_lock got locked=%b sc=%0d want 1 1", lk[1], sc[1]);
      end
   endtask

   task automatic test_fail;
      thr = 24'hFFFFFF;
      do_start(1'b0);
      for (int s = 1; s <= 4; s++) begin
         drive_epoch(7, 7);
         drive_epoch(7, 7);
         checks++;
         if (sc[2] !== 11'(s) || fl[2] !== (s == 4) || by[2] !== (s != 4)) begin
            failures++;
            $display("FAIL exhaust s=%0d got sc=%0d fail=%b busy=%b", s, sc[2], fl[2], by[2]);
         end
      end
   endtask

   task automatic test_restart;
      thr = 24'hFFFFFF;
      do_start(1'b0);
      for (int e = 0; e < 8; e++) drive_epoch(50, 50);
      checks++;
      if (pk[0] !== 24'd400 || sc[0] !== 11'd1) begin
         failures++;
         $display("FAIL pre_restart got pk=%0d sc=%0d want 400 1", pk[0], sc[0]);
      end
      do_start(1'b1);
      checks++;
      if (pk[0] !== '0 || sc[0] !== '0 || by[0] !== 1'b1) begin
         failures++;
         $display("FAIL restart got pk=%0d sc=%0d busy=%b want 0 0 1", pk[0], sc[0], by[0]);
      end
      drive_epoch(10, 10);
      for (int e = 0; e < 3; e++) drive_epoch(20, 20);
      checks++;
      if (seen[0] !== 1'b0 || sc[0] !== '0) begin
         failures++;
         $display("FAIL restart_discard got sr=%b sc=%0d want 0 0", seen[0], sc[0]);
      end
      drive_epoch(20, 20);
      checks++;
      if (dw[0] !== 24'd160 || seen[0] !== 1'b1) begin
         failures++;
         $display("FAIL restart_dwell got dw=%0d sr=%b want 160 1", dw[0], seen[0]);
      end
   endtask

   task automatic test_saturation;
      thr = 24'hFFFFFF;
      do_start(1'b0);
      for (int e = 0; e < 5; e++) drive_epoch(-524288, -524288);
      checks++;
      if (dw[3] !== 24'd2097151 || pk[3] !== 24'd2097151 || by[3] !== 1'b1) begin
         failures++;
         $display("FAIL saturate got dw=%0d pk=%0d busy=%b want 2097151 2097151 1",
                  dw[3], pk[3], by[3]);
      end
      for (int e = 0; e < 4; e++) drive_epoch(1, 1);
      checks++;
      if (dw[3] !== 24'd8) begin
         failures++;
         $display("FAIL sat_clear got dw=%0d want 8", dw[3]);
      end
   endtask

   task automatic test_random;
      do_start(1'b0);
      for (int n = 0; n < 300; n++) begin
         int iv, qv;
         if ($urandom_range(0, 39) == 0) do_start(1'($urandom));
         thr = 24'($urandom_range(0, 6000));
         if ($urandom_range(0, 19) == 0) begin
            iv = -524288;
            qv = -524288;
         end else begin
            iv = int'($urandom_range(0, 2000)) - 1000;
            qv = int'($urandom_range(0, 2000)) - 1000;
         end
         drive_epoch(iv, qv);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (seen[k] !== pulse[k] || sc[k] !== 11'(slips[k]) ||
                dw[k] !== 24'(mdw[k]) || pk[k] !== 24'(mpk[k]) ||
                lk[k] !== (mode[k] == 3) || fl[k] !== (mode[k] == 4) ||
                by[k] !== (mode[k] == 1 || mode[k] == 2) ||
                nslip[k] - base[k] != slips[k]) begin
               failures++;
               $display("FAIL rand n=%0d k=%0d got sr=%b sc=%0d dw=%0d pk=%0d lk=%b fl=%b by=%b want sr=%b sc=%0d dw=%0d pk=%0d mode=%0d",
                        n, k, seen[k], sc[k], dw[k], pk[k], lk[k], fl[k], by[k],
                        pulse[k], slips[k], mdw[k], mpk[k], mode[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_magnitude;
      test_search;
      test_lock;
      test_confirm_abort;
      test_fail;
      test_restart;
      test_saturation;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
